// File: rtl/display_decoder_if.sv
// Bus bundle for the four-digit seven-segment display decoder.
// The master drives the digits and display controls; the slave (the decoder)
// drives the active-low segment, decimal-point and anode lines.
interface display_decoder_if;
  logic [15:0] bcd;
  logic        blank_lz;
  logic        blink_en;
  logic [3:0]  dp_mask;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  modport master (
    output bcd, blank_lz, blink_en, dp_mask,
    input  seg, dp, an
  );

  modport slave (
    input  bcd, blank_lz, blink_en, dp_mask,
    output seg, dp, an
  );
endinterface

// File: rtl/display_decoder.sv
// Four-digit multiplexed seven-segment display driver.
// Each digit is driven for REFRESH_DIV clocks in turn (digit0 first).
// The BCD word is frozen once per frame, so a mid-frame update never tears
// the display. Leading zeros can be blanked and the whole display can blink
// with a half-period of BLINK_DIV clocks. All outputs are registered and
// active-low.
module display_decoder #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 25000000
) (
  input logic              clk,
  input logic              reset,
  display_decoder_if.slave bus
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [6:0]    SEG_OFF    = 7'h7F;

  logic [RW-1:0] refCnt_q, refCnt_d;
  logic [1:0]    scanIdx_q, scanIdx_d;
  logic [BW-1:0] blinkCnt_q, blinkCnt_d;
  logic          blinkPhase_q, blinkPhase_d;
  logic [15:0]   snap_q, snap_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;

  logic          frameStart;
  logic [15:0]   frameBcd;
  logic [3:0]    digit;
  logic          leadingZero;

  // Active-low segment pattern for one digit; non-decimal values show a dash.
  function automatic logic [6:0] decodeDigit(input logic [3:0] value);
    logic [6:0] pattern;
    case (value)
      4'd0:    pattern = 7'h40;
      4'd1:    pattern = 7'h79;
      4'd2:    pattern = 7'h24;
      4'd3:    pattern = 7'h30;
      4'd4:    pattern = 7'h19;
      4'd5:    pattern = 7'h12;
      4'd6:    pattern = 7'h02;
      4'd7:    pattern = 7'h78;
      4'd8:    pattern = 7'h00;
      4'd9:    pattern = 7'h10;
      default: pattern = 7'h3F;
    endcase
    return pattern;
  endfunction

  // Scan timing: slot counter, digit index and the per-frame BCD snapshot.
  // The live bcd is used directly in the frame-start cycle so the whole frame,
  // including its very first cycle, shows the same captured value.
  always_comb begin
    refCnt_d   = refCnt_q + 1'b1;
    scanIdx_d  = scanIdx_q;
    if (refCnt_q == REF_LAST) begin
      refCnt_d  = '0;
      scanIdx_d = scanIdx_q + 2'd1;
    end
    frameStart = (refCnt_q == '0) && (scanIdx_q == 2'd0);
    frameBcd   = frameStart ? bus.bcd : snap_q;
    snap_d     = frameBcd;
  end

  // Blink timing: runs only while blinking is enabled, otherwise parked at the
  // visible phase so every enable starts with a full visible half-period.
  always_comb begin
    blinkCnt_d   = '0;
    blinkPhase_d = 1'b0;
    if (bus.blink_en) begin
      if (blinkCnt_q == BLINK_LAST) begin
        blinkCnt_d   = '0;
        blinkPhase_d = ~blinkPhase_q;
      end else begin
        blinkCnt_d   = blinkCnt_q + 1'b1;
        blinkPhase_d = blinkPhase_q;
      end
    end
  end

  // Output decode for the digit currently being scanned, with leading-zero
  // blanking (segments only) and the blink-off override of everything.
  always_comb begin
    digit       = frameBcd[3:0];
    leadingZero = 1'b0;
    case (scanIdx_q)
      2'd1: begin
        digit       = frameBcd[7:4];
        leadingZero = (frameBcd[15:4] == 12'h000);
      end
      2'd2: begin
        digit       = frameBcd[11:8];
        leadingZero = (frameBcd[15:8] == 8'h00);
      end
      2'd3: begin
        digit       = frameBcd[15:12];
        leadingZero = (frameBcd[15:12] == 4'h0);
      end
      default: begin
        digit       = frameBcd[3:0];
        leadingZero = 1'b0;
      end
    endcase

    an_d  = ~(4'b0001 << scanIdx_q);
    seg_d = (bus.blank_lz && leadingZero) ? SEG_OFF : decodeDigit(digit);
    dp_d  = ~bus.dp_mask[scanIdx_q];

    if (bus.blink_en && blinkPhase_q) begin
      an_d  = 4'hF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
    end
  end

  // State and output registers; reset blanks the display and restarts a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      refCnt_q     <= '0;
      scanIdx_q    <= 2'd0;
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
      snap_q       <= 16'h0000;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      an_q         <= 4'hF;
    end else begin
      refCnt_q     <= refCnt_d;
      scanIdx_q    <= scanIdx_d;
      blinkCnt_q   <= blinkCnt_d;
      blinkPhase_q <= blinkPhase_d;
      snap_q       <= snap_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;
  assign bus.an  = an_q;

endmodule
